// File: rtl/vx_operand_collector.sv
// Operand collector: accepts one issued instruction, reads its live source registers
// from a single-ported GPR file and hands the assembled operand packet to dispatch.
module vx_operand_collector #(
   parameter string INSTANCE_ID = "",
   parameter int NUM_OPDS = 3,
   parameter int NUM_THREADS = 4,
   parameter int XLEN = 32,
   parameter int NR_BITS = 5,
   parameter int ISSUE_WIS_W = 2,
   parameter int UUID_W = 16,
   parameter int PC_W = 32,
   parameter int EX_TYPE_W = 3,
   parameter int OP_TYPE_W = 4,
   parameter int OP_ARGS_W = 8,
   parameter int RRS_W = 4,
   localparam int DATA_W = NUM_THREADS * XLEN,
   localparam int IN_W = UUID_W + ISSUE_WIS_W + NUM_THREADS + PC_W + EX_TYPE_W + OP_TYPE_W
                         + OP_ARGS_W + 1 + NR_BITS + RRS_W + NUM_OPDS * NR_BITS + NUM_OPDS,
   localparam int OUT_W = UUID_W + ISSUE_WIS_W + NUM_THREADS + PC_W + EX_TYPE_W + OP_TYPE_W
                          + OP_ARGS_W + 1 + NR_BITS + NUM_OPDS * DATA_W + RRS_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [IN_W-1:0]        in_data,
   output logic                   in_ready,
   output logic                   gpr_req_valid,
   output logic [ISSUE_WIS_W-1:0] gpr_req_wis,
   output logic [NR_BITS-1:0]     gpr_req_rid,
   input  logic [DATA_W-1:0]      gpr_rsp_data,
   output logic                   out_valid,
   output logic [OUT_W-1:0]       out_data,
   input  logic                   out_ready
);

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, SEND} state_e;

   typedef struct packed {
      logic [UUID_W-1:0]                   uuid;
      logic [ISSUE_WIS_W-1:0]              wis;
      logic [NUM_THREADS-1:0]              tmask;
      logic [PC_W-1:0]                     pc;
      logic [EX_TYPE_W-1:0]                ex_type;
      logic [OP_TYPE_W-1:0]                op_type;
      logic [OP_ARGS_W-1:0]                op_args;
      logic                                wb;
      logic [NR_BITS-1:0]                  rd;
      logic [RRS_W-1:0]                    rrs_id;
      logic [0:NUM_OPDS-1][NR_BITS-1:0]    rs;
      logic [NUM_OPDS-1:0]                 used_rs;
   } in_t;

   typedef struct packed {
      logic [UUID_W-1:0]                   uuid;
      logic [ISSUE_WIS_W-1:0]              wis;
      logic [NUM_THREADS-1:0]              tmask;
      logic [PC_W-1:0]                     pc;
      logic [EX_TYPE_W-1:0]                ex_type;
      logic [OP_TYPE_W-1:0]                op_type;
      logic [OP_ARGS_W-1:0]                op_args;
      logic                                wb;
      logic [NR_BITS-1:0]                  rd;
      logic [0:NUM_OPDS-1][DATA_W-1:0]     rs_data;
      logic [RRS_W-1:0]                    rrs_id;
   } out_t;

   in_t    in_s;
   state_e state_q, state_d;
   out_t   out_q, out_d;
   logic   out_valid_q, out_valid_d;
   logic   req_valid_q, req_valid_d;
   logic [NR_BITS-1:0] req_rid_q, req_rid_d;
   logic [1:0] req_slot_q, req_slot_d;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] len_q, len_d;
   logic [NUM_OPDS-1:0][NR_BITS-1:0] list_rid_q, list_rid_d;
   logic [NUM_OPDS-1:0][1:0]         list_slot_q, list_slot_d;
   logic       rsp_pend_q, rsp_pend_d;
   logic [1:0] rsp_slot_q, rsp_slot_d;

   logic [NUM_OPDS-1:0][NR_BITS-1:0] new_rid;
   logic [NUM_OPDS-1:0][1:0]         new_slot;
   logic [1:0]                       new_len;
   logic                             accept;

   assign in_s     = in_data;
   assign in_ready = reset && ((state_q == IDLE) || (state_q == SEND && out_ready));
   assign accept   = in_valid && in_ready;

   // Compact read list: only operands that are used and not x0, kept in rs1..rs3 order.
   always_comb begin
      new_rid  = '0;
      new_slot = '0;
      new_len  = '0;
      for (int k = 0; k < NUM_OPDS; k++) begin
         if (in_s.used_rs[k] && (in_s.rs[k] != '0)) begin
            new_rid[new_len]  = in_s.rs[k];
            new_slot[new_len] = 2'(k);
            new_len           = new_len + 2'd1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      req_valid_d = 1'b0;
      req_rid_d   = req_rid_q;
      req_slot_d  = req_slot_q;
      ptr_d       = ptr_q;
      len_d       = len_q;
      list_rid_d  = list_rid_q;
      list_slot_d = list_slot_q;
      rsp_pend_d  = req_valid_q;
      rsp_slot_d  = req_slot_q;

      case (state_q)
         FETCH: begin
            if (ptr_q == len_q) begin
               state_d = WAIT;
            end else begin
               req_valid_d = 1'b1;
               req_rid_d   = list_rid_q[ptr_q];
               req_slot_d  = list_slot_q[ptr_q];
               ptr_d       = ptr_q + 2'd1;
            end
         end
         WAIT: begin
            state_d     = SEND;
            out_valid_d = 1'b1;
         end
         SEND: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: ;
      endcase

      // A new instruction may enter from IDLE or in the same cycle SEND fires.
      if (accept) begin
         out_d.uuid    = in_s.uuid;
         out_d.wis     = in_s.wis;
         out_d.tmask   = in_s.tmask;
         out_d.pc      = in_s.pc;
         out_d.ex_type = in_s.ex_type;
         out_d.op_type = in_s.op_type;
         out_d.op_args = in_s.op_args;
         out_d.wb      = in_s.wb;
         out_d.rd      = in_s.rd;
         out_d.rrs_id  = in_s.rrs_id;
         out_d.rs_data = '0;
         list_rid_d    = new_rid;
         list_slot_d   = new_slot;
         len_d         = new_len;
         if (new_len == 2'd0) begin
            state_d     = SEND;
            out_valid_d = 1'b1;
            ptr_d       = '0;
         end else begin
            state_d     = FETCH;
            out_valid_d = 1'b0;
            req_valid_d = 1'b1;
            req_rid_d   = new_rid[0];
            req_slot_d  = new_slot[0];
            ptr_d       = 2'd1;
         end
      end

      if (rsp_pend_q) begin
         out_d.rs_data[rsp_slot_q] = gpr_rsp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         req_valid_q <= 1'b0;
         req_rid_q   <= '0;
         req_slot_q  <= '0;
         ptr_q       <= '0;
         len_q       <= '0;
         list_rid_q  <= '0;
         list_slot_q <= '0;
         rsp_pend_q  <= 1'b0;
         rsp_slot_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         req_valid_q <= req_valid_d;
         req_rid_q   <= req_rid_d;
         req_slot_q  <= req_slot_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         list_rid_q  <= list_rid_d;
         list_slot_q <= list_slot_d;
         rsp_pend_q  <= rsp_pend_d;
         rsp_slot_q  <= rsp_slot_d;
      end
   end

   assign gpr_req_valid = req_valid_q;
   assign gpr_req_wis   = out_q.wis;
   assign gpr_req_rid   = req_rid_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_q;

endmodule

// File: tb/tb_vx_operand_collector.sv
// Self-checking bench for vx_operand_collector: vector table, GPR responder model
// and a scoreboard of expected packets, requests and latencies.
module tb_vx_operand_collector;

   localparam int NUM_OPDS = 3;
   localparam int NUM_THREADS = 4;
   localparam int XLEN = 32;
   localparam int NR_BITS = 5;
   localparam int WIS_W = 2;
   localparam int UUID_W = 16;
   localparam int PC_W = 32;
   localparam int EX_W = 3;
   localparam int OPT_W = 4;
   localparam int ARGS_W = 8;
   localparam int RRS_W = 4;
   localparam int DATA_W = NUM_THREADS * XLEN;
   localparam int IN_W = UUID_W + WIS_W + NUM_THREADS + PC_W + EX_W + OPT_W + ARGS_W + 1
                         + NR_BITS + RRS_W + NUM_OPDS * NR_BITS + NUM_OPDS;
   localparam int OUT_W = UUID_W + WIS_W + NUM_THREADS + PC_W + EX_W + OPT_W + ARGS_W + 1
                          + NR_BITS + NUM_OPDS * DATA_W + RRS_W;

   typedef struct packed {
      logic [UUID_W-1:0]                uuid;
      logic [WIS_W-1:0]                 wis;
      logic [NUM_THREADS-1:0]           tmask;
      logic [PC_W-1:0]                  pc;
      logic [EX_W-1:0]                  ex_type;
      logic [OPT_W-1:0]                 op_type;
      logic [ARGS_W-1:0]                op_args;
      logic                             wb;
      logic [NR_BITS-1:0]               rd;
      logic [RRS_W-1:0]                 rrs_id;
      logic [0:NUM_OPDS-1][NR_BITS-1:0] rs;
      logic [NUM_OPDS-1:0]              used_rs;
   } in_t;

   typedef struct packed {
      logic [UUID_W-1:0]               uuid;
      logic [WIS_W-1:0]                wis;
      logic [NUM_THREADS-1:0]          tmask;
      logic [PC_W-1:0]                 pc;
      logic [EX_W-1:0]                 ex_type;
      logic [OPT_W-1:0]                op_type;
      logic [ARGS_W-1:0]               op_args;
      logic                            wb;
      logic [NR_BITS-1:0]              rd;
      logic [0:NUM_OPDS-1][DATA_W-1:0] rs_data;
      logic [RRS_W-1:0]                rrs_id;
   } out_t;

   typedef struct {
      int wis;
      int used;
      int r1;
      int r2;
      int r3;
      int lat;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic [IN_W-1:0]   in_data;
   logic              in_ready;
   logic              gpr_req_valid;
   logic [WIS_W-1:0]  gpr_req_wis;
   logic [NR_BITS-1:0] gpr_req_rid;
   logic [DATA_W-1:0] gpr_rsp_data;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic              out_ready;

   vx_operand_collector #(.INSTANCE_ID("tb")) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .gpr_req_valid(gpr_req_valid),
      .gpr_req_wis  (gpr_req_wis),
      .gpr_req_rid  (gpr_req_rid),
      .gpr_rsp_data (gpr_rsp_data),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chki(string nm, int act, int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: actual %0d required %0d", nm, act, exp);
      end
   endfunction

   function automatic void chkw(string nm, logic [OUT_W-1:0] act, logic [OUT_W-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endfunction

   function automatic void failEvent(string nm);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: actual event seen required none", nm);
   endfunction

   // GPR file model: distinct per warp/reg/thread except the x5/x7 constants of warp 0.
   logic [XLEN-1:0] gm [4][32][NUM_THREADS];

   function automatic logic [DATA_W-1:0] gprRow(int w, int r);
      logic [DATA_W-1:0] row;
      for (int t = 0; t < NUM_THREADS; t++) row[t*XLEN +: XLEN] = gm[w][r][t];
      return row;
   endfunction

   logic              rsp_pend = 1'b0;
   logic [WIS_W-1:0]  rsp_wis = '0;
   logic [NR_BITS-1:0] rsp_rid = '0;

   always @(negedge clk) begin
      rsp_pend = gpr_req_valid;
      rsp_wis  = gpr_req_wis;
      rsp_rid  = gpr_req_rid;
   end

   always @(posedge clk) begin
      if (rsp_pend === 1'b1) gpr_rsp_data <= gprRow(int'(rsp_wis), int'(rsp_rid));
      else gpr_rsp_data <= {$urandom, $urandom, $urandom, $urandom};
   end

   function automatic out_t model(in_t i);
      out_t o;
      o = '0;
      o.uuid = i.uuid; o.wis = i.wis; o.tmask = i.tmask; o.pc = i.pc;
      o.ex_type = i.ex_type; o.op_type = i.op_type; o.op_args = i.op_args;
      o.wb = i.wb; o.rd = i.rd; o.rrs_id = i.rrs_id;
      for (int k = 0; k < NUM_OPDS; k++)
         if (i.used_rs[k] && i.rs[k] != '0) o.rs_data[k] = gprRow(int'(i.wis), int'(i.rs[k]));
      return o;
   endfunction

   function automatic in_t mk(vec_t v);
      in_t i;
      i.uuid = UUID_W'($urandom); i.wis = WIS_W'(v.wis); i.tmask = NUM_THREADS'($urandom);
      i.pc = $urandom; i.ex_type = EX_W'($urandom); i.op_type = OPT_W'($urandom);
      i.op_args = ARGS_W'($urandom); i.wb = 1'($urandom); i.rd = NR_BITS'($urandom);
      i.rrs_id = RRS_W'($urandom);
      i.rs[0] = NR_BITS'(v.r1); i.rs[1] = NR_BITS'(v.r2); i.rs[2] = NR_BITS'(v.r3);
      i.used_rs = NUM_OPDS'(v.used);
      return i;
   endfunction

   out_t exp_q[$];
   int   lat_q[$];
   logic [WIS_W+NR_BITS-1:0] req_q[$];
   int   next_lat = 0;
   bit   seen_first = 0;
   int   acc_cnt = 0;
   int   fire_cnt = 0;
   int   last_fire_cyc = 0;
   in_t  mon_in;

   // Scoreboard: requests, first-valid latency and packet contents, all checked mid-cycle.
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               failEvent("unexpected_out");
            end else begin
               if (!seen_first) begin
                  chki("latency", cyc, lat_q[0]);
                  seen_first = 1;
               end
               chkw("out_data", out_data, exp_q[0]);
            end
            if (out_ready) begin
               chki("in_ready_on_fire", int'(in_ready), 1);
               if (exp_q.size() != 0) begin
                  void'(exp_q.pop_front());
                  void'(lat_q.pop_front());
               end
               seen_first = 0;
               fire_cnt++;
               last_fire_cyc = cyc;
            end else begin
               chki("bp_in_ready", int'(in_ready), 0);
               chki("bp_no_req", int'(gpr_req_valid), 0);
            end
         end
         if (gpr_req_valid) begin
            if (req_q.size() == 0) failEvent("unexpected_req");
            else chki("gpr_req", int'({gpr_req_wis, gpr_req_rid}), int'(req_q.pop_front()));
         end
         if (in_valid && in_ready) begin
            mon_in = in_data;
            exp_q.push_back(model(mon_in));
            lat_q.push_back(cyc + next_lat);
            for (int k = 0; k < NUM_OPDS; k++)
               if (mon_in.used_rs[k] && mon_in.rs[k] != '0) req_q.push_back({mon_in.wis, mon_in.rs[k]});
            acc_cnt++;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic applyStimulus(input in_t ins, output int acc_cyc);
      bit done = 0;
      in_valid = 1'b1;
      in_data  = ins;
      acc_cyc  = 0;
      for (int b = 0; b < 60 && !done; b++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1;
            acc_cyc = cyc;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) failEvent("accept_timeout");
   endtask

   task automatic checkOutput();
      int b = 0;
      while (fire_cnt != acc_cnt && b < 60) begin
         @(negedge clk);
         b++;
      end
      if (fire_cnt != acc_cnt) failEvent("drain_timeout");
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual timeout required completion");
      $fatal(1);
   end

   vec_t vecs[8];
   vec_t v;
   int   acc0;
   int   acc_tmp;
   int   fires0;
   int   bsum;
   bit   hit;

   initial begin
      vecs[0] = '{0, 3'b011, 5, 7, 0, 4};
      vecs[1] = '{0, 3'b011, 0, 0, 9, 1};
      vecs[2] = '{1, 3'b111, 1, 2, 3, 5};
      vecs[3] = '{2, 3'b001, 4, 0, 0, 3};
      vecs[4] = '{3, 3'b110, 0, 6, 8, 4};
      vecs[5] = '{1, 3'b101, 0, 3, 31, 3};
      vecs[6] = '{0, 3'b000, 5, 6, 7, 1};
      vecs[7] = '{2, 3'b111, 0, 0, 0, 1};

      for (int w = 0; w < 4; w++)
         for (int r = 0; r < 32; r++)
            for (int t = 0; t < NUM_THREADS; t++)
               gm[w][r][t] = {8'(w), 8'(r), 8'(t), 8'h3C};
      for (int t = 0; t < NUM_THREADS; t++) begin
         gm[0][5][t] = 32'h11;
         gm[0][7][t] = 32'h22;
      end

      reset = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chki("rst_in_ready", int'(in_ready), 0);
      chki("rst_out_valid", int'(out_valid), 0);
      chki("rst_gpr_req", int'(gpr_req_valid), 0);
      chkw("rst_out_data", out_data, '0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chki("in_ready_after_rst", int'(in_ready), 1);
      @(posedge clk); #1;

      $display("[TB] single instructions from the vector table");
      for (int i = 0; i < 8; i++) begin
         next_lat = vecs[i].lat;
         applyStimulus(mk(vecs[i]), acc_tmp);
         checkOutput();
      end

      $display("[TB] backpressure in SEND");
      out_ready = 1'b0;
      next_lat = vecs[0].lat;
      applyStimulus(mk(vecs[0]), acc_tmp);
      hit = 0;
      for (int b = 0; b < 20 && !hit; b++) begin
         @(negedge clk);
         hit = out_valid;
      end
      if (!hit) failEvent("bp_valid_timeout");
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
      checkOutput();

      $display("[TB] back-to-back stream");
      fires0 = fire_cnt;
      bsum = 0;
      for (int i = 0; i < 4; i++) begin
         v = (i == 0) ? vecs[0] : vecs[i + 1];
         bsum += v.lat;
         next_lat = v.lat;
         applyStimulus(mk(v), acc_tmp);
         if (i == 0) acc0 = acc_tmp;
      end
      checkOutput();
      chki("b2b_total_cycles", last_fire_cyc - acc0, bsum);
      chki("b2b_packets", fire_cnt - fires0, 4);

      $display("[TB] reset during second read");
      next_lat = vecs[2].lat;
      applyStimulus(mk(vecs[2]), acc_tmp);
      hit = 0;
      for (int b = 0; b < 20 && !hit; b++) begin
         @(negedge clk);
         hit = gpr_req_valid && (gpr_req_rid == NR_BITS'(2));
      end
      if (!hit) failEvent("second_read_timeout");
      #1 reset = 1'b0;
      exp_q.delete();
      lat_q.delete();
      req_q.delete();
      seen_first = 0;
      acc_cnt = fire_cnt;
      @(posedge clk); #1;
      reset = 1'b1;
      next_lat = vecs[1].lat;
      in_valid = 1'b1;
      in_data = mk(vecs[1]);
      @(negedge clk);
      chki("rst_mid_out_valid", int'(out_valid), 0);
      chki("rst_mid_gpr_req", int'(gpr_req_valid), 0);
      chki("rst_mid_in_ready", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput();
      next_lat = vecs[0].lat;
      applyStimulus(mk(vecs[0]), acc_tmp);
      checkOutput();

      chki("scoreboard_empty", exp_q.size(), 0);
      chki("requests_consumed", req_q.size(), 0);
      chki("accepted_eq_sent", fire_cnt, acc_cnt);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
